// File: rtl/input_debounce.sv
// Conditions one raw asynchronous input: synchronizes it, accepts a level only after
// it has been stable for DEBOUNCE cycles, and reports rise/fall/glitch as single-cycle pulses.
module input_debounce #(
    parameter int SYNC_STAGES = 2,      // 2..4
    parameter int DEBOUNCE    = 16,     // 1..65535
    parameter bit INVERT      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          glitch_q, glitch_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Reset value of s equals INVERT, matching the reset value of dout, so release is edge-free.
    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        case (state_q)
            STABLE: begin
                if (s == dout_q) begin
                    cnt_d = '0;
                end else if (DEBOUNCE == 1) begin
                    dout_d = s;
                    rise_d = s;
                    fall_d = ~s;
                    cnt_d  = '0;
                end else begin
                    cnt_d   = CW'(1);
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (s == dout_q) begin
                    glitch_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = STABLE;
                end else if (cnt_q == LAST) begin
                    dout_d  = s;
                    rise_d  = s;
                    fall_d  = ~s;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = STABLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            dout_q   <= INVERT;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign dout   = dout_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign glitch = glitch_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: DUT a uses SYNC_STAGES=2/DEBOUNCE=4, DUT b uses
// DEBOUNCE=1 with INVERT=1. Expected edges are hand-computed from the stated latencies.
module tb_input_debounce;

    logic clk = 1'b0;
    logic rst_a = 1'b0, din_a = 1'b0;
    logic rst_b = 1'b0, din_b = 1'b0;
    logic dout_a, rise_a, fall_a, glitch_a;
    logic dout_b, rise_b, fall_b, glitch_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-edge history, index 1 = first edge after the stimulus change
    logic d_a[1:32], r_a[1:32], f_a[1:32], g_a[1:32];
    logic d_b[1:32], r_b[1:32], f_b[1:32], g_b[1:32];

    always #5 clk = ~clk;

    input_debounce #(.SYNC_STAGES(2), .DEBOUNCE(4), .INVERT(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .din(din_a),
        .dout(dout_a), .rise(rise_a), .fall(fall_a), .glitch(glitch_a)
    );

    input_debounce #(.SYNC_STAGES(2), .DEBOUNCE(1), .INVERT(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .din(din_b),
        .dout(dout_b), .rise(rise_b), .fall(fall_b), .glitch(glitch_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs edges first..last (inclusive) and records both DUTs after each edge
    task automatic run(input int first, input int last);
        for (int e = first; e <= last; e++) begin
            tick();
            d_a[e] = dout_a; r_a[e] = rise_a; f_a[e] = fall_a; g_a[e] = glitch_a;
            d_b[e] = dout_b; r_b[e] = rise_b; f_b[e] = fall_b; g_b[e] = glitch_b;
        end
    endtask

    function automatic int count_a(input int which, input int last);
        int c = 0;
        for (int e = 1; e <= last; e++) begin
            case (which)
                0: c += int'(d_a[e]);
                1: c += int'(r_a[e]);
                2: c += int'(f_a[e]);
                default: c += int'(g_a[e]);
            endcase
        end
        return c;
    endfunction

    initial begin
        // Reset values, asserted mid-cycle with no clock edge
        #3;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check("rst_dout_a", 32'(dout_a), 32'd0);
        check("rst_pulses_a", 32'({rise_a, fall_a, glitch_a}), 32'd0);
        check("rst_dout_b_inv", 32'(dout_b), 32'd1);
        check("rst_pulses_b", 32'({rise_b, fall_b, glitch_b}), 32'd0);
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        run(1, 20);
        check("idle_pulses_a", 32'(count_a(1, 20) + count_a(2, 20) + count_a(3, 20)), 32'd0);
        check("idle_dout_a", 32'(count_a(0, 20)), 32'd0);

        // Rejected glitch: high for 3 samples
        din_a = 1'b1;
        run(1, 3);
        din_a = 1'b0;
        run(4, 10);
        check("glitch_e5", 32'(g_a[5]), 32'd0);
        check("glitch_e6", 32'(g_a[6]), 32'd1);
        check("glitch_e7", 32'(g_a[7]), 32'd0);
        check("glitch_count", 32'(count_a(3, 10)), 32'd1);
        check("glitch_no_rise", 32'(count_a(1, 10)), 32'd0);
        check("glitch_dout_low", 32'(count_a(0, 10)), 32'd0);

        // Accepted rise
        din_a = 1'b1;
        run(1, 10);
        check("rise_dout_e5", 32'(d_a[5]), 32'd0);
        check("rise_dout_e6", 32'(d_a[6]), 32'd1);
        check("rise_e5", 32'(r_a[5]), 32'd0);
        check("rise_e6", 32'(r_a[6]), 32'd1);
        check("rise_e7", 32'(r_a[7]), 32'd0);
        check("rise_no_fall_glitch", 32'(count_a(2, 10) + count_a(3, 10)), 32'd0);

        // Accepted fall at the exact 4-sample boundary, then a normal re-rise
        din_a = 1'b0;
        run(1, 4);
        din_a = 1'b1;
        run(5, 14);
        check("fall_e5", 32'(f_a[5]), 32'd0);
        check("fall_e6", 32'(f_a[6]), 32'd1);
        check("fall_dout_e6", 32'(d_a[6]), 32'd0);
        check("rerise_e9", 32'(r_a[9]), 32'd0);
        check("rerise_e10", 32'(r_a[10]), 32'd1);
        check("rerise_dout_e10", 32'(d_a[10]), 32'd1);
        check("fall_count", 32'(count_a(2, 14)), 32'd1);
        check("fall_no_glitch", 32'(count_a(3, 14)), 32'd0);

        // Return to low before the reset scenario
        din_a = 1'b0;
        run(1, 12);
        check("settle_fall_e6", 32'(f_a[6]), 32'd1);

        // Reset while PENDING
        din_a = 1'b1;
        run(1, 4);
        #2;
        rst_a = 1'b1;
        #1;
        check("midrst_dout", 32'(dout_a), 32'd0);
        check("midrst_pulses", 32'({rise_a, fall_a, glitch_a}), 32'd0);
        tick();
        rst_a = 1'b0;
        run(1, 10);
        check("postrst_rise_e5", 32'(r_a[5]), 32'd0);
        check("postrst_dout_e5", 32'(d_a[5]), 32'd0);
        check("postrst_rise_e6", 32'(r_a[6]), 32'd1);
        check("postrst_no_glitch", 32'(count_a(3, 10)), 32'd0);

        // INVERT=1, DEBOUNCE=1
        din_b = 1'b1;
        run(1, 5);
        check("inv_dout_e2", 32'(d_b[2]), 32'd1);
        check("inv_fall_e2", 32'(f_b[2]), 32'd0);
        check("inv_fall_e3", 32'(f_b[3]), 32'd1);
        check("inv_dout_e3", 32'(d_b[3]), 32'd0);
        check("inv_fall_e4", 32'(f_b[4]), 32'd0);
        din_b = 1'b0;
        run(1, 5);
        check("inv_rise_e2", 32'(r_b[2]), 32'd0);
        check("inv_rise_e3", 32'(r_b[3]), 32'd1);
        check("inv_rdout_e3", 32'(d_b[3]), 32'd1);
        check("inv_rise_e4", 32'(r_b[4]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
